// File: rtl/uart_rx_core.sv
// Oversampling UART receiver: 2-flop synchroniser, false-start rejection, LSB-first framing, wrapping load address.
// Optional parity check is compiled in by defining UART_RX_PARITY_EN.
module uart_rx_core #(
  parameter int CLK_DIV    = 9375,
  parameter int DATA_BITS  = 8,
  parameter int ADDR_W     = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_p,
  input  logic                 uart_rx,
  input  logic                 addr_clr,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic [ADDR_W-1:0]    data_addr,
  output logic                 busy
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  if (CLK_DIV < 4 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
    $error("uart_rx_core: unsupported parameter set");
  end

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_IDLE} state_t;
`endif

  state_t               state_q, state_d;
  logic                 sync1_q, rx_s_q, rx_prev_q;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 rx_valid_q, rx_valid_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 frame_err_q, frame_err_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
`ifdef UART_RX_PARITY_EN
  logic                 perr_q, perr_d;
  logic                 parity_err_q, parity_err_d;
`endif

  always_ff @(posedge clk) begin
    if (rst_p) begin
      sync1_q     <= 1'b1;
      rx_s_q      <= 1'b1;
      rx_prev_q   <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      rx_valid_q  <= 1'b0;
      rx_data_q   <= '0;
      frame_err_q <= 1'b0;
      addr_q      <= '0;
`ifdef UART_RX_PARITY_EN
      perr_q       <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      sync1_q     <= uart_rx;
      rx_s_q      <= sync1_q;
      rx_prev_q   <= rx_s_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      rx_valid_q  <= rx_valid_d;
      rx_data_q   <= rx_data_d;
      frame_err_q <= frame_err_d;
      addr_q      <= addr_d;
`ifdef UART_RX_PARITY_EN
      perr_q       <= perr_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    idx_d       = idx_q;
    shift_d     = shift_q;
    rx_valid_d  = 1'b0;
    rx_data_d   = rx_data_q;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d       = perr_q;
    parity_err_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (rx_prev_q && !rx_s_q) state_d = S_START;
      end
      S_START: begin
        // Mid-start-bit sample: a line already back high was only a glitch.
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s_q;
          idx_d          = idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          perr_d  = ((^shift_q) ^ rx_s_q) != (PARITY_ODD != 0);
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s_q) begin
            rx_valid_d = 1'b1;
            rx_data_d  = shift_q;
`ifdef UART_RX_PARITY_EN
            parity_err_d = perr_q;
`endif
            state_d = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_WAIT_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        cnt_d = '0;
        if (rx_s_q) state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Clear wins over the increment for the byte being presented.
  always_comb begin
    addr_d = addr_q;
    if (addr_clr)        addr_d = '0;
    else if (rx_valid_q) addr_d = addr_q + ADDR_W'(1);
  end

  assign rx_valid  = rx_valid_q;
  assign rx_data   = rx_data_q;
  assign frame_err = frame_err_q;
  assign data_addr = addr_q;
  assign busy      = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule
